alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Issue stage directly upstream of the ALU. Accepts {opcode, A, B} over valid/ready and decodes the
//  opcode into an ALU select plus prepared operands; SUB becomes ADD with ~B and carry-in 1.
//  Holds up to two operations in a skid buffer and presents them in order to the ALU over valid/ready.
// PARAMETERS
//  WIDTH  32  operand width (bits)
//  CNT_W  16  width of issued-operation counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      upstream op valid
//  in_ready     out  1      stage can accept (in_valid&&in_ready = accept)
//  in_opcode    in   4      ADD=0010 SUB=0011 AND=0100 OR=0101 NOT=0110
//  in_a         in   WIDTH  operand A
//  in_b         in   WIDTH  operand B (ignored for NOT)
//  out_valid    out  1      op presented to ALU
//  out_ready    in   1      ALU consumes (out_valid&&out_ready = issue)
//  out_sel      out  2      alu_sel_t: ADD=0 AND=1 OR=2 NOT=3
//  out_a        out  WIDTH  operand A
//  out_b        out  WIDTH  prepared B: ~in_b for SUB, 0 for NOT, else in_b
//  out_cin      out  1      carry-in: 1 for SUB only
//  issue_cnt    out  CNT_W  count of issued ops, wraps 2^CNT_W-1 -> 0
//  err_illegal  out  1      sticky illegal-opcode flag (see CONFIGURATION)
//  err_opcode   out  4      opcode that raised err_illegal
//  err_clear    in   1      one-cycle pulse clears err_illegal/err_opcode
// BEHAVIOUR
//  - Reset (rst=1 at edge): both entries flushed, out_valid=0, out_sel/out_a/out_b/out_cin=0,
//    issue_cnt=0, err_illegal=0, err_opcode=0. in_ready=0 while rst=1. Reset mid-operation drops
//    all held ops; none is issued.
//  - Decode happens on accept; entries store decoded {sel,a,b,cin}.
//  - FSM on occupancy: EMPTY -> ONE on accept. ONE -> EMPTY on issue without accept; stays ONE on
//    accept+issue (main reloaded). ONE -> TWO on accept without issue (op goes to skid reg).
//    TWO -> ONE on issue (skid moves to main). No accept in TWO.
//  - in_ready = !rst && state!=TWO && !err_illegal. Registered state only; no in->out comb path.
//  - Latency: op accepted at edge N is out_valid from cycle N+1 if the stage was EMPTY. Throughput:
//    1 op/cycle when out_ready held 1.
//  - out_* stable while out_valid && !out_ready (AXI-style hold). Strict FIFO order.
//  - issue_cnt increments by 1 on each issue; modulo 2^CNT_W.
//  - Illegal opcode = any value outside the five above.
// CONFIGURATION
//  ALU_ILLEGAL_TRAP_EN defined: an illegal op is accepted but not enqueued. Next cycle
//    err_illegal=1 and err_opcode=opcode. in_ready=0 until err_clear. Held entries still drain.
//    err_clear clears both at the next edge.
//  ALU_ILLEGAL_TRAP_EN undefined: an illegal op is accepted and silently dropped.
//    err_illegal/err_opcode tied 0; err_clear ignored.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD..OP_NOT), alu_sel_t enum, issue_entry_t
//    {sel,a,b,cin}, occupancy state enum.
//  Sub-module alu_skid_buf: 2-entry ordered skid buffer of issue_entry_t with valid/ready on
//    both sides. Top holds decode, counter, error logic.
// TESTING
//  1. ADD a=5 b=3, out_ready=1 -> next cycle out_sel=ADD a=5 b=3 cin=0; issue_cnt=1.
//  2. SUB a=10 b=4 -> out_sel=ADD, out_b=32'hFFFFFFFB, cin=1 (ALU yields 6).
//  3. out_ready=0, send ops X,Y -> in_ready=0 after Y; Z stalls. Raise out_ready -> X,Y,Z issued
//     in order on consecutive cycles.
//  4. NOT a=32'h0F0F0F0F b=32'h1234 -> out_sel=NOT out_b=0 cin=0; AND/OR pass b unchanged.
//  5. Opcode 4'b1111: with ALU_ILLEGAL_TRAP_EN -> err_illegal=1, err_opcode=F, in_ready=0 until
//     err_clear. Without it -> op dropped, issue_cnt unchanged.
//  6. rst asserted in TWO state -> next cycle out_valid=0, issue_cnt=0; held ops never issued.
//     Preset issue_cnt=16'hFFFF plus one issue -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, ALU select, issue entry and occupancy state.
// Also holds the opcode legality check and the decode helper used on accept.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;

    typedef enum logic [1:0] {
        SEL_ADD = 2'd0,
        SEL_AND = 2'd1,
        SEL_OR  = 2'd2,
        SEL_NOT = 2'd3
    } alu_sel_t;

    typedef struct packed {
        alu_sel_t               sel;
        logic [ALU_WIDTH-1:0]   a;
        logic [ALU_WIDTH-1:0]   b;
        logic                   cin;
    } issue_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT};
    endfunction

    // SUB is folded into ADD as a + ~b + 1 so the ALU only needs one adder.
    function automatic issue_entry_t decode_op(input logic [3:0]           op,
                                               input logic [ALU_WIDTH-1:0] a,
                                               input logic [ALU_WIDTH-1:0] b);
        issue_entry_t e;
        e   = '0;
        e.a = a;
        case (op)
            OP_ADD:  begin e.sel = SEL_ADD; e.b = b; end
            OP_SUB:  begin e.sel = SEL_ADD; e.b = ~b; e.cin = 1'b1; end
            OP_AND:  begin e.sel = SEL_AND; e.b = b; end
            OP_OR:   begin e.sel = SEL_OR;  e.b = b; end
            OP_NOT:  e.sel = SEL_NOT;
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry ordered skid buffer of decoded issue entries, valid/ready on both sides.
// Readiness and validity depend on registered occupancy only.
module alu_skid_buf
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  issue_entry_t in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output issue_entry_t out_data_o
);

    occ_state_t   state_q, state_d;
    issue_entry_t main_q, main_d;
    issue_entry_t skid_q, skid_d;
    logic         push, pop;

    assign in_ready_o  = (state_q != OCC_TWO);
    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = main_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    main_d  = in_data_i;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    main_d = in_data_i;
                end else if (push) begin
                    skid_d  = in_data_i;
                    state_d = OCC_TWO;
                end else if (pop) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            // NOTE: payload registers are reset too, because the ALU-facing outputs must read zero after reset.
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes accepted ops into {sel,a,b,cin}, buffers two in order, counts issues.
// Optional illegal-opcode trap enabled by defining ALU_ILLEGAL_TRAP_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sel,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin,
    output logic [CNT_W-1:0] issue_cnt,
    output logic             err_illegal,
    output logic [3:0]       err_opcode,
    input  logic             err_clear
);

    logic             accept, op_legal, enq_valid;
    logic             buf_in_ready, err_block;
    issue_entry_t     dec_entry, buf_out;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    assign op_legal  = op_is_legal(in_opcode);
    assign dec_entry = decode_op(in_opcode, in_a, in_b);
    assign in_ready  = !rst && buf_in_ready && !err_block;
    assign accept    = in_valid && in_ready;
    // Illegal ops are still handshaken upstream; they just never reach the buffer.
    assign enq_valid = accept && op_legal;

    alu_skid_buf u_skid_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (enq_valid),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (dec_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (buf_out)
    );

    assign out_sel = buf_out.sel;
    assign out_a   = buf_out.a;
    assign out_b   = buf_out.b;
    assign out_cin = buf_out.cin;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (out_valid && out_ready) issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) issue_cnt_q <= '0;
        else     issue_cnt_q <= issue_cnt_d;
    end

    assign issue_cnt = issue_cnt_q;

`ifdef ALU_ILLEGAL_TRAP_EN
    logic       err_illegal_q, err_illegal_d;
    logic [3:0] err_opcode_q, err_opcode_d;

    always_comb begin
        err_illegal_d = err_illegal_q;
        err_opcode_d  = err_opcode_q;
        if (accept && !op_legal) begin
            err_illegal_d = 1'b1;
            err_opcode_d  = in_opcode;
        end else if (err_clear) begin
            err_illegal_d = 1'b0;
            err_opcode_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal_q <= 1'b0;
            err_opcode_q  <= '0;
        end else begin
            err_illegal_q <= err_illegal_d;
            err_opcode_q  <= err_opcode_d;
        end
    end

    assign err_block   = err_illegal_q;
    assign err_illegal = err_illegal_q;
    assign err_opcode  = err_opcode_q;
`else
    logic unused_err_clear;

    assign unused_err_clear = err_clear;
    assign err_block        = 1'b0;
    assign err_illegal      = 1'b0;
    assign err_opcode       = '0;
`endif

endmodule
